// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO between the MEM-stage store port and data memory.
// Drains over req/ack, forwards exact full-word hits to loads, and supports a fence drain.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_st_valid,
  input  logic [AW-1:0]            i_st_addr,
  input  logic [DW-1:0]            i_st_data,
  input  logic [DW/8-1:0]          i_st_be,
  output logic                     o_st_stall,
  input  logic [AW-1:0]            i_ld_addr,
  output logic                     o_ld_hit,
  output logic [DW-1:0]            o_ld_data,
  output logic                     o_ld_conflict,
  output logic                     o_mem_req,
  output logic [AW-1:0]            o_mem_addr,
  output logic [DW-1:0]            o_mem_data,
  output logic [DW/8-1:0]          o_mem_be,
  input  logic                     i_mem_ack,
  input  logic                     i_fence,
  output logic                     o_fence_done,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int BW = DW / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = AW - 2;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [BW-1:0] be_q   [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop;

  logic          match;
  logic [DW-1:0] m_data;
  logic [BW-1:0] m_be;
  logic [PW-1:0] idx;

  // Byte offsets are irrelevant: everything is word granular.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_st_addr[1:0], i_ld_addr[1:0]};

  assign full       = (count == CW'(DEPTH));
  assign o_st_stall = full || (state_q != S_RUN);
  assign push       = i_st_valid && !o_st_stall;
  assign o_mem_req  = (count != '0);
  assign pop        = o_mem_req && i_mem_ack;

  assign o_mem_addr = {addr_q[rd_ptr], 2'b00};
  assign o_mem_data = data_q[rd_ptr];
  assign o_mem_be   = be_q[rd_ptr];
  assign o_count    = count;

  // Entry storage; payload is not reset, validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= i_st_addr[AW-1:2];
      data_q[wr_ptr] <= i_st_data;
      be_q[wr_ptr]   <= i_st_be;
    end
  end

  // Pointer and occupancy bookkeeping; reset drops all queued stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Fence state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  // Fence next-state and done pulse.
  always_comb begin
    state_d      = state_q;
    o_fence_done = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (i_fence) state_d = (count == '0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (count == '0) state_d = S_DONE;
      end
      S_DONE: begin
        o_fence_done = 1'b1;
        state_d      = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Load lookup: walk oldest to youngest so the youngest match wins.
  always_comb begin
    match  = 1'b0;
    m_data = '0;
    m_be   = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) &&
          (addr_q[idx] == i_ld_addr[AW-1:2])) begin
        match  = 1'b1;
        m_data = data_q[idx];
        m_be   = be_q[idx];
      end
    end
  end

  assign o_ld_hit      = match && (&m_be);
  assign o_ld_conflict = match && !(&m_be);
  assign o_ld_data     = o_ld_hit ? m_data : '0;

endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: vector table plus memory-side scoreboard
// for the posted-store write buffer.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_st_valid;
  logic [31:0] i_st_addr;
  logic [31:0] i_st_data;
  logic [3:0]  i_st_be;
  logic        o_st_stall;
  logic [31:0] i_ld_addr;
  logic        o_ld_hit;
  logic [31:0] o_ld_data;
  logic        o_ld_conflict;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic        i_fence;
  logic        o_fence_done;
  logic [2:0]  o_count;

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .i_st_valid(i_st_valid), .i_st_addr(i_st_addr),
    .i_st_data(i_st_data), .i_st_be(i_st_be),
    .o_st_stall(o_st_stall), .i_ld_addr(i_ld_addr),
    .o_ld_hit(o_ld_hit), .o_ld_data(o_ld_data),
    .o_ld_conflict(o_ld_conflict), .o_mem_req(o_mem_req),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_be(o_mem_be), .i_mem_ack(i_mem_ack),
    .i_fence(i_fence), .o_fence_done(o_fence_done),
    .o_count(o_count)
  );

  typedef struct {
    logic        rst;
    logic        sv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [3:0]  sbe;
    logic [31:0] la;
    logic        ack;
    logic        fen;
    logic        chk;
    int          ecnt;
    logic        estall;
    logic        ehit;
    logic        econf;
    logic [31:0] eld;
    logic        edone;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  vec_t vecs[$];
  ent_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input int r,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0h, expected %0h",
               nm, r, act, exp);
    end
  endtask

  task automatic row(input logic rst, input logic sv,
                     input logic [31:0] sa, input logic [31:0] sd,
                     input logic [3:0] sbe, input logic [31:0] la,
                     input logic ack, input logic fen,
                     input logic chk, input int ecnt,
                     input logic estall, input logic ehit,
                     input logic econf, input logic [31:0] eld,
                     input logic edone);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sa = sa; v.sd = sd; v.sbe = sbe;
    v.la = la; v.ack = ack; v.fen = fen; v.chk = chk;
    v.ecnt = ecnt; v.estall = estall; v.ehit = ehit;
    v.econf = econf; v.eld = eld; v.edone = edone;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int r);
    ent_t e;
    @(negedge clk);
    reset      = v.rst;
    i_st_valid = v.sv;
    i_st_addr  = v.sa;
    i_st_data  = v.sd;
    i_st_be    = v.sbe;
    i_ld_addr  = v.la;
    i_mem_ack  = v.ack;
    i_fence    = v.fen;
    #1;
    if (v.chk) begin
      check("count", r, 32'(o_count), 32'(v.ecnt));
      check("stall", r, 32'(o_st_stall), 32'(v.estall));
      check("req", r, 32'(o_mem_req), 32'(v.ecnt != 0));
      check("ld_hit", r, 32'(o_ld_hit), 32'(v.ehit));
      check("ld_conflict", r, 32'(o_ld_conflict), 32'(v.econf));
      check("ld_data", r, o_ld_data, v.eld);
      check("fence_done", r, 32'(o_fence_done), 32'(v.edone));
      if (o_mem_req === 1'b1) begin
        if (sb.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL mem_req (row %0d): req=1, expected no entry", r);
        end else begin
          check("mem_addr", r, o_mem_addr, sb[0].a);
          check("mem_data", r, o_mem_data, sb[0].d);
          check("mem_be", r, 32'(o_mem_be), 32'(sb[0].be));
          if (v.ack) void'(sb.pop_front());
        end
      end
      if (v.sv && !v.estall) begin
        e.a  = v.sa & ~32'h3;
        e.d  = v.sd;
        e.be = v.sbe;
        sb.push_back(e);
      end
    end
    if (v.rst) sb.delete();
  endtask

  initial begin
    int waited;
    reset = 1'b1; i_st_valid = 1'b0; i_st_addr = '0; i_st_data = '0;
    i_st_be = '0; i_ld_addr = '0; i_mem_ack = 1'b0; i_fence = 1'b0;

    // rst sv  sa      sd           sbe   la     ack fen chk cnt stl hit cnf ld           dn
    row(1, 0, 0,      0,           0,    0,     0, 0, 0, 0, 0, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    0,     0, 0, 1, 0, 0, 0, 0, 0,           0);
    row(0, 1, 'h10,   'hDEADBEEF,  'hF,  'h10,  0, 0, 1, 0, 0, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    'h13,  0, 0, 1, 1, 0, 1, 0, 'hDEADBEEF,  0);
    row(0, 0, 0,      0,           0,    0,     0, 0, 1, 1, 0, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    0,     0, 0, 1, 1, 0, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    0,     1, 0, 1, 1, 0, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    0,     0, 0, 1, 0, 0, 0, 0, 0,           0);
    row(0, 1, 'h100,  1,           'hF,  0,     0, 0, 1, 0, 0, 0, 0, 0,           0);
    row(0, 1, 'h104,  2,           'hF,  0,     0, 0, 1, 1, 0, 0, 0, 0,           0);
    row(0, 1, 'h108,  3,           'hF,  0,     0, 0, 1, 2, 0, 0, 0, 0,           0);
    row(0, 1, 'h10C,  4,           'hF,  0,     0, 0, 1, 3, 0, 0, 0, 0,           0);
    row(0, 1, 'h110,  5,           'hF,  0,     0, 0, 1, 4, 1, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    'h110, 1, 0, 1, 4, 1, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    'h104, 0, 0, 1, 3, 0, 1, 0, 2,           0);
    row(0, 0, 0,      0,           0,    0,     1, 0, 1, 3, 0, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    0,     1, 0, 1, 2, 0, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    0,     1, 0, 1, 1, 0, 0, 0, 0,           0);
    row(0, 1, 'h20,   1,           'hF,  0,     0, 0, 1, 0, 0, 0, 0, 0,           0);
    row(0, 1, 'h20,   2,           'hF,  'h20,  0, 0, 1, 1, 0, 1, 0, 1,           0);
    row(0, 0, 0,      0,           0,    'h22,  0, 0, 1, 2, 0, 1, 0, 2,           0);
    row(0, 1, 'h24,   'h55,        'h3,  'h24,  0, 0, 1, 2, 0, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    'h24,  0, 0, 1, 3, 0, 0, 1, 0,           0);
    row(0, 0, 0,      0,           0,    'h28,  1, 0, 1, 3, 0, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    'h20,  1, 0, 1, 2, 0, 1, 0, 2,           0);
    row(0, 0, 0,      0,           0,    'h20,  1, 0, 1, 1, 0, 0, 0, 0,           0);
    row(0, 1, 'h30,   'hA0,        'hF,  0,     0, 0, 1, 0, 0, 0, 0, 0,           0);
    row(0, 1, 'h34,   'hA1,        'hF,  0,     0, 0, 1, 1, 0, 0, 0, 0,           0);
    row(0, 1, 'h38,   'hA2,        'hF,  0,     1, 0, 1, 2, 0, 0, 0, 0,           0);
    row(0, 1, 'h3C,   'hA3,        'hF,  0,     1, 0, 1, 2, 0, 0, 0, 0,           0);
    row(0, 1, 'h40,   'hA4,        'hF,  0,     1, 0, 1, 2, 0, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    'h40,  1, 0, 1, 2, 0, 1, 0, 'hA4,        0);
    row(0, 0, 0,      0,           0,    0,     1, 0, 1, 1, 0, 0, 0, 0,           0);
    row(0, 1, 'h50,   'hB0,        'hF,  0,     0, 0, 1, 0, 0, 0, 0, 0,           0);
    row(0, 1, 'h54,   'hB1,        'hF,  0,     0, 0, 1, 1, 0, 0, 0, 0,           0);
    row(0, 1, 'h58,   'hB2,        'hF,  0,     0, 0, 1, 2, 0, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    0,     1, 1, 1, 3, 0, 0, 0, 0,           0);
    row(0, 1, 'h5C,   'hB3,        'hF,  0,     1, 1, 1, 2, 1, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    0,     1, 1, 1, 1, 1, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    0,     0, 1, 1, 0, 1, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    0,     0, 1, 1, 0, 1, 0, 0, 0,           1);
    row(0, 0, 0,      0,           0,    0,     0, 1, 1, 0, 0, 0, 0, 0,           0);
    row(0, 0, 0,      0,           0,    0,     0, 0, 1, 0, 1, 0, 0, 0,           1);
    row(0, 0, 0,      0,           0,    0,     0, 0, 1, 0, 0, 0, 0, 0,           0);
    row(0, 1, 'h60,   'hC0,        'hF,  0,     0, 0, 1, 0, 0, 0, 0, 0,           0);
    row(0, 1, 'h64,   'hC1,        'hF,  0,     0, 0, 1, 1, 0, 0, 0, 0,           0);
    row(1, 0, 0,      0,           0,    'h60,  1, 0, 1, 2, 0, 1, 0, 'hC0,        0);
    row(0, 0, 0,      0,           0,    'h60,  0, 0, 1, 0, 0, 0, 0, 0,           0);

    for (int r = 0; r < vecs.size(); r++) apply(vecs[r], r);

    // Unaligned store address, partial be: first req one cycle after push.
    @(negedge clk);
    reset = 1'b0; i_mem_ack = 1'b0; i_fence = 1'b0; i_ld_addr = '0;
    i_st_valid = 1'b1; i_st_addr = 32'h73;
    i_st_data = 32'h12345678; i_st_be = 4'h5;
    @(negedge clk);
    i_st_valid = 1'b0;
    #1;
    waited = 0;
    while (o_mem_req !== 1'b1 && waited < 5) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("req_latency", -1, 32'(waited), 32'd0);
    check("aligned_addr", -1, o_mem_addr, 32'h70);
    check("seq_data", -1, o_mem_data, 32'h12345678);
    check("seq_be", -1, 32'(o_mem_be), 32'h5);
    i_mem_ack = 1'b1;
    @(negedge clk);
    i_mem_ack = 1'b0;
    #1;
    check("drained_count", -1, 32'(o_count), 32'd0);
    check("drained_req", -1, 32'(o_mem_req), 32'd0);

    // Reset mid-fence: buffer empties and the fence is abandoned.
    @(negedge clk);
    i_st_valid = 1'b1; i_st_addr = 32'h80; i_st_data = 32'h1;
    i_st_be = 4'hF;
    @(negedge clk);
    i_st_valid = 1'b0; i_fence = 1'b1;
    @(negedge clk);
    i_fence = 1'b0;
    #1;
    check("drain_stall", -1, 32'(o_st_stall), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_stall", -1, 32'(o_st_stall), 32'd0);
    check("rst_count", -1, 32'(o_count), 32'd0);
    check("rst_done", -1, 32'(o_fence_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
